hack_screen_scanout: RTL and testbench
======================================

// Module: hack_screen_scanout
// PURPOSE
// - Consumes de/hs/vs from the LCD timing generator and drives RGB565 pixels from Hack screen RAM
//   (512x256 monochrome, 8192 x 16-bit words, row-major, 32 words per row, bit 0 = leftmost pixel).
// - Fetches one word per 16 pixels from a synchronous, 1-cycle-latency VRAM read port.
// - Shows the Hack screen windowed on the panel; sits between timing generator and LCD pins.
// PARAMETERS
// - V_OFFSET    8        active panel line that shows screen row 0 (rows on lines V_OFFSET..V_OFFSET+255)
// - H_WORD_OFF  1        first row word shown (0..2); 30 words = 480 px, default crops 16 px each side
// - H_PIXELS    480      max active pixels per line taken from VRAM; pixels beyond this are border
// - VS_POL      1'b0     active level of vs_in
// - FG_RGB      16'h0000 RGB565 for bit=1 (Hack black)
// - BG_RGB      16'hFFFF RGB565 for bit=0 (Hack white)
// - BORDER_RGB  16'h001F RGB565 outside the window (only with HACK_SCANOUT_BORDER_EN)
// PORTS
// - dclk       in   1   pixel clock
// - reset      in   1   async, active-high
// - de_in      in   1   data enable from timing generator
// - hs_in      in   1   hsync from timing generator
// - vs_in      in   1   vsync from timing generator
// - vram_rd    out  1   read strobe; data valid on vram_data next cycle
// - vram_addr  out  13  word address = row*32 + H_WORD_OFF + word index
// - vram_data  in   16  read data
// - lcd_de/hs/vs out 1  de_in/hs_in/vs_in delayed 1 cycle
// - lcd_r/g/b  out  5/6/5 pixel colour, aligned with lcd_de
// BEHAVIOUR
// - Reset (async, active-high), clocked on dclk: all outputs 0; counters 0; synced=0.
// - synced=0 until first vs_in edge into VS_POL; while unsynced: no reads, window pixels=border.
// - vs edge into VS_POL: line=0, x=0, synced=1; if line 0 in window, prefetch word 0 of row 0.
// - de_in fall: line+=1 (saturate at 1023), x=0; if new line in window, prefetch its word 0.
// - vs edge and de fall in same cycle: vs rule wins.
// - Window: synced && V_OFFSET<=line<V_OFFSET+256 && x<H_PIXELS; row=line-V_OFFSET.
// - Prefetch: vram_rd=1 one cycle, addr=row*32+H_WORD_OFF; next cycle data -> buf.
// - Active pixel (de_in=1), x[3:0]==0: shreg<=buf; issue read for word (x>>4)+1 if still in window;
//   returned data lands in buf before next 16-group; pixel bit = buf[0] at x%16==0 else shreg bit x[3:0].
// - x increments each de_in cycle, 10 bits, never wraps within a line.
// - Output registered: lcd_rgb = bit ? FG_RGB : BG_RGB in window; border otherwise; 0 when de_in=0.
// - Latency de_in -> lcd_de exactly 1 cycle; hs/vs same; at most 1 read per 16 dclk in active video.
// - vram_addr holds last value when vram_rd=0; no read is issued outside the window.
// - Reset mid-line: outputs drop to 0 at once; resumes only after next vs edge.
// CONFIGURATION
// - HACK_SCANOUT_BORDER_EN defined: out-of-window active pixels = BORDER_RGB.
// - Undefined: out-of-window active pixels = 16'h0000; BORDER_RGB unused.
// STRUCTURE
// - Package hack_screen_pkg: SCREEN_W=512, SCREEN_H=256, WORDS_PER_ROW=32, VRAM_AW=13,
//   typedef rgb565_t (packed r[4:0], g[5:0], b[4:0]), function rgb565_unpack.
// - One sub-module: lcd_sync_delay (1-cycle de/hs/vs register with async reset to 0).
// TESTING
// - Reset asserted mid-line -> all outputs 0 same cycle; no vram_rd until first vs edge after release.
// - VRAM word 32*0+1 = 16'h0001, vs then line V_OFFSET -> first pixel FG_RGB, next 15 BG_RGB.
// - Word 32*255+30 = 16'h8000 -> line V_OFFSET+255, x=479 is FG_RGB; x=0..478 from their words.
// - Count vram_rd per active line in window -> 30 strobes + 1 prefetch; 0 on lines outside window.
// - Line V_OFFSET-1 and V_OFFSET+256 -> border (macro on) or 0 (macro off); no reads.
// - vs edge coincident with de fall -> line=0, only row 0 prefetch issued; lcd_* lag inputs by 1 cycle.

Source files
------------

// File: rtl/hack_screen_pkg.sv
// Shared constants and pixel types for the Hack screen scan-out path.
// The screen is 512x256 monochrome, stored as 8192 16-bit words, 32 words per row.
package hack_screen_pkg;

    localparam int SCREEN_W      = 512;
    localparam int SCREEN_H      = 256;
    localparam int WORDS_PER_ROW = 32;
    localparam int VRAM_AW       = 13;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic rgb565_t rgb565_unpack(input logic [15:0] raw);
        return rgb565_t'(raw);
    endfunction

endpackage

// File: rtl/hack_screen_scanout_sync.sv
// One-cycle register for the LCD sync strobes so that they line up with the registered pixel colour.
module lcd_sync_delay (
    input  logic dclk,
    input  logic reset,
    input  logic de_in,
    input  logic hs_in,
    input  logic vs_in,
    output logic lcd_de,
    output logic lcd_hs,
    output logic lcd_vs
);

    logic [2:0] sync_d;
    logic [2:0] sync_q;

    always_comb begin
        sync_d = {de_in, hs_in, vs_in};
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign lcd_de = sync_q[2];
    assign lcd_hs = sync_q[1];
    assign lcd_vs = sync_q[0];

endmodule

// File: rtl/hack_screen_scanout.sv
// Hack screen scan-out: windows the 512x256 Hack framebuffer onto the LCD timing stream.
// Build option HACK_SCANOUT_BORDER_EN: out-of-window active pixels use BORDER_RGB instead of black.
module hack_screen_scanout
    import hack_screen_pkg::*;
#(
    parameter int          V_OFFSET   = 8,
    parameter int          H_WORD_OFF = 1,
    parameter int          H_PIXELS   = 480,
    parameter logic        VS_POL     = 1'b0,
    parameter logic [15:0] FG_RGB     = 16'h0000,
    parameter logic [15:0] BG_RGB     = 16'hFFFF,
    parameter logic [15:0] BORDER_RGB = 16'h001F
) (
    input  logic               dclk,
    input  logic               reset,
    input  logic               de_in,
    input  logic               hs_in,
    input  logic               vs_in,
    output logic               vram_rd,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [15:0]        vram_data,
    output logic               lcd_de,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic [4:0]         lcd_r,
    output logic [5:0]         lcd_g,
    output logic [4:0]         lcd_b
);

    localparam int                 H_CLAMP  = (H_PIXELS < SCREEN_W) ? H_PIXELS : SCREEN_W;
    localparam logic [9:0]         H_LIMIT  = 10'(H_CLAMP);
    localparam logic [9:0]         V_FIRST  = 10'(V_OFFSET);
    localparam logic [9:0]         V_END    = 10'(V_OFFSET + SCREEN_H);
    localparam logic [VRAM_AW-1:0] WORD_OFF = VRAM_AW'(H_WORD_OFF);

`ifdef HACK_SCANOUT_BORDER_EN
    localparam logic [15:0] OUT_BORDER = BORDER_RGB;
`else
    // Without the border option the surround is black; the colour parameter is masked away.
    localparam logic [15:0] OUT_BORDER = BORDER_RGB & 16'h0000;
`endif

    logic               synced_q, synced_d;
    logic               vs_prev_q, vs_prev_d;
    logic [9:0]         line_q, line_d;
    logic [9:0]         x_q, x_d;
    logic [15:0]        buf_q, buf_d;
    logic [15:0]        shreg_q, shreg_d;
    logic               rd_valid_q, rd_valid_d;
    logic               vram_rd_q, vram_rd_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    rgb565_t            rgb_q, rgb_d;

    logic vs_edge;
    logic de_fall;
    logic win;
    logic pix_bit;

    function automatic logic in_rows(input logic [9:0] line);
        return (line >= V_FIRST) && (line < V_END);
    endfunction

    function automatic logic [VRAM_AW-1:0] word_addr(input logic [9:0] line, input logic [5:0] word);
        logic [7:0] row;
        row = 8'(line - V_FIRST);
        return VRAM_AW'(row) * VRAM_AW'(WORDS_PER_ROW) + WORD_OFF + VRAM_AW'(word);
    endfunction

    lcd_sync_delay u_sync (
        .dclk   (dclk),
        .reset  (reset),
        .de_in  (de_in),
        .hs_in  (hs_in),
        .vs_in  (vs_in),
        .lcd_de (lcd_de),
        .lcd_hs (lcd_hs),
        .lcd_vs (lcd_vs)
    );

    // The delayed DE doubles as the previous-cycle DE for falling-edge detection.
    always_comb begin
        synced_d   = synced_q;
        vs_prev_d  = vs_in;
        line_d     = line_q;
        x_d        = x_q;
        buf_d      = buf_q;
        shreg_d    = shreg_q;
        rd_valid_d = vram_rd_q;
        vram_rd_d  = 1'b0;
        addr_d     = addr_q;
        rgb_d      = '0;
        pix_bit    = 1'b0;

        vs_edge = (vs_in == VS_POL) && (vs_prev_q != VS_POL);
        de_fall = lcd_de && !de_in;
        win     = synced_q && in_rows(line_q) && (x_q < H_LIMIT);

        if (rd_valid_q) begin
            buf_d = vram_data;
        end

        if (de_in) begin
            if (x_q != 10'h3FF) begin
                x_d = x_q + 10'd1;
            end
            if (win) begin
                pix_bit = (x_q[3:0] == 4'd0) ? buf_q[0] : shreg_q[x_q[3:0]];
                rgb_d   = rgb565_unpack(pix_bit ? FG_RGB : BG_RGB);
                if (x_q[3:0] == 4'd0) begin
                    shreg_d   = buf_q;
                    vram_rd_d = 1'b1;
                    addr_d    = word_addr(line_q, x_q[9:4] + 6'd1);
                end
            end else begin
                rgb_d = rgb565_unpack(OUT_BORDER);
            end
        end

        // A frame start overrides a coincident end-of-line.
        if (vs_edge) begin
            line_d   = 10'd0;
            x_d      = 10'd0;
            synced_d = 1'b1;
            if (in_rows(10'd0)) begin
                vram_rd_d = 1'b1;
                addr_d    = word_addr(10'd0, 6'd0);
            end
        end else if (de_fall) begin
            line_d = (line_q == 10'h3FF) ? line_q : line_q + 10'd1;
            x_d    = 10'd0;
            if (synced_q && in_rows(line_d)) begin
                vram_rd_d = 1'b1;
                addr_d    = word_addr(line_d, 6'd0);
            end
        end
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            synced_q   <= 1'b0;
            vs_prev_q  <= VS_POL;
            line_q     <= '0;
            x_q        <= '0;
            buf_q      <= '0;
            shreg_q    <= '0;
            rd_valid_q <= 1'b0;
            vram_rd_q  <= 1'b0;
            addr_q     <= '0;
            rgb_q      <= '0;
        end else begin
            synced_q   <= synced_d;
            vs_prev_q  <= vs_prev_d;
            line_q     <= line_d;
            x_q        <= x_d;
            buf_q      <= buf_d;
            shreg_q    <= shreg_d;
            rd_valid_q <= rd_valid_d;
            vram_rd_q  <= vram_rd_d;
            addr_q     <= addr_d;
            rgb_q      <= rgb_d;
        end
    end

    assign vram_rd   = vram_rd_q;
    assign vram_addr = addr_q;
    assign lcd_r     = rgb_q.r;
    assign lcd_g     = rgb_q.g;
    assign lcd_b     = rgb_q.b;

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Directed bench for hack_screen_scanout with a synchronous VRAM model and default parameters.
// Expectations follow HACK_SCANOUT_BORDER_EN when the bench is built with it.
module tb_hack_screen_scanout;

    localparam logic [15:0] FG = 16'h0000;
    localparam logic [15:0] BG = 16'hFFFF;
`ifdef HACK_SCANOUT_BORDER_EN
    localparam logic [15:0] EXP_BORDER = 16'h001F;
`else
    localparam logic [15:0] EXP_BORDER = 16'h0000;
`endif

    logic        dclk = 1'b0;
    logic        reset = 1'b1;
    logic        de_in = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        vram_rd;
    logic [12:0] vram_addr;
    logic [15:0] vram_data = 16'h0000;
    logic        lcd_de, lcd_hs, lcd_vs;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;

    logic [15:0] mem [0:8191];
    logic [15:0] pix [0:1023];
    int          rd_cnt;
    logic [12:0] first_addr;
    int          total = 0;
    int          bad = 0;

    hack_screen_scanout dut (
        .dclk      (dclk),
        .reset     (reset),
        .de_in     (de_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .vram_rd   (vram_rd),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .lcd_de    (lcd_de),
        .lcd_hs    (lcd_hs),
        .lcd_vs    (lcd_vs),
        .lcd_r     (lcd_r),
        .lcd_g     (lcd_g),
        .lcd_b     (lcd_b)
    );

    always #5 dclk = ~dclk;

    always @(posedge dclk) begin
        if (vram_rd) vram_data <= mem[vram_addr];
    end

    function automatic logic [15:0] lcd_rgb();
        return {lcd_r, lcd_g, lcd_b};
    endfunction

    function automatic logic [15:0] exp_pix(input int row, input int x);
        logic [15:0] word;
        word = mem[row * 32 + 1 + x / 16];
        return word[x % 16] ? FG : BG;
    endfunction

    // Inputs apply for one dclk; outputs are looked at 1 ns after the edge that registers them.
    task automatic drive_cycle(input logic de, input logic hs, input logic vs);
        de_in = de;
        hs_in = hs;
        vs_in = vs;
        @(posedge dclk);
        #1;
        if (vram_rd) begin
            if (rd_cnt == 0) first_addr = vram_addr;
            rd_cnt++;
        end
    endtask

    task automatic drive_line(input int blank, input int active);
        rd_cnt = 0;
        first_addr = '0;
        for (int i = 0; i < blank; i++) drive_cycle(1'b0, (i == 1) ? 1'b0 : 1'b1, 1'b1);
        for (int i = 0; i < active; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1);
            pix[i] = lcd_rgb();
        end
    endtask

    task automatic vs_pulse();
        drive_cycle(1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1);
    endtask

    task automatic check_border_line(input string name, input int active);
        int wrong;
        wrong = 0;
        for (int i = 0; i < active; i++) if (pix[i] !== EXP_BORDER) wrong++;
        total++;
        if (wrong != 0) begin
            bad++;
            $display("[TB] FAIL %s: %0d pixels differ, pixel0=%h required=%h", name, wrong, pix[0], EXP_BORDER);
        end
        total++;
        if (rd_cnt !== 0) begin
            bad++;
            $display("[TB] FAIL %s reads: got %0d required 0", name, rd_cnt);
        end
    endtask

    task automatic check_window_line(input string name, input int row);
        int wrong;
        int first_bad;
        wrong = 0;
        first_bad = -1;
        for (int i = 0; i < 480; i++) begin
            if (pix[i] !== exp_pix(row, i)) begin
                if (first_bad < 0) first_bad = i;
                wrong++;
            end
        end
        total++;
        if (wrong != 0) begin
            bad++;
            $display("[TB] FAIL %s pixels: %0d wrong, first x=%0d got=%h required=%h",
                     name, wrong, first_bad, pix[first_bad], exp_pix(row, first_bad));
        end
        total++;
        if (rd_cnt !== 31) begin
            bad++;
            $display("[TB] FAIL %s reads: got %0d required 31", name, rd_cnt);
        end
        total++;
        if (first_addr !== 13'(row * 32 + 1)) begin
            bad++;
            $display("[TB] FAIL %s prefetch addr: got %0d required %0d", name, first_addr, row * 32 + 1);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({lcd_de, lcd_hs, lcd_vs, vram_rd} !== 4'b0000 || lcd_rgb() !== 16'h0000 || vram_addr !== 13'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: de/hs/vs/rd=%b%b%b%b rgb=%h addr=%0d required all 0",
                     lcd_de, lcd_hs, lcd_vs, vram_rd, lcd_rgb(), vram_addr);
        end
        @(posedge dclk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_unsynced();
        int reads;
        reads = 0;
        for (int l = 0; l < 10; l++) begin
            drive_line(4, 6);
            reads += rd_cnt;
        end
        rd_cnt = reads;
        check_border_line("unsynced", 6);
    endtask

    task automatic test_first_word();
        vs_pulse();
        drive_line(0, 2);
        for (int l = 1; l < 7; l++) drive_line(4, 2);
        drive_line(4, 8);
        check_border_line("line_above_window", 8);
        drive_line(4, 480);
        total++;
        if (pix[0] !== FG) begin
            bad++;
            $display("[TB] FAIL first_pixel: got %h required %h", pix[0], FG);
        end
        for (int i = 1; i < 16; i++) begin
            total++;
            if (pix[i] !== BG) begin
                bad++;
                $display("[TB] FAIL first_word_x%0d: got %h required %h", i, pix[i], BG);
            end
        end
        total++;
        if (pix[17] !== FG) begin
            bad++;
            $display("[TB] FAIL second_word_x17: got %h required %h", pix[17], FG);
        end
        check_window_line("row0", 0);
    endtask

    task automatic test_last_row();
        for (int l = 9; l < 263; l++) drive_line(4, 1);
        drive_line(4, 480);
        total++;
        if (pix[479] !== FG) begin
            bad++;
            $display("[TB] FAIL last_pixel: got %h required %h", pix[479], FG);
        end
        total++;
        if (pix[478] !== BG) begin
            bad++;
            $display("[TB] FAIL x478: got %h required %h", pix[478], BG);
        end
        check_window_line("row255", 255);
        drive_line(4, 20);
        check_border_line("line_below_window", 20);
    endtask

    task automatic test_coincident();
        int reads;
        drive_cycle(1'b1, 1'b0, 1'b1);
        total++;
        if ({lcd_de, lcd_hs, lcd_vs} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL lag_active: de/hs/vs=%b%b%b required 101", lcd_de, lcd_hs, lcd_vs);
        end
        rd_cnt = 0;
        drive_cycle(1'b0, 1'b1, 1'b0);
        total++;
        if ({lcd_de, lcd_hs, lcd_vs, vram_rd} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL lag_vs_fall: de/hs/vs/rd=%b%b%b%b required 0100", lcd_de, lcd_hs, lcd_vs, vram_rd);
        end
        drive_cycle(1'b0, 1'b1, 1'b1);
        reads = rd_cnt;
        drive_line(0, 2);
        reads += rd_cnt;
        for (int l = 1; l < 8; l++) begin
            drive_line(4, 2);
            reads += rd_cnt;
        end
        total++;
        if (reads !== 0) begin
            bad++;
            $display("[TB] FAIL coincident_pre_window_reads: got %0d required 0", reads);
        end
        drive_line(4, 2);
        total++;
        if (rd_cnt !== 2 || first_addr !== 13'd1) begin
            bad++;
            $display("[TB] FAIL coincident_row0: reads=%0d addr=%0d required 2 and 1", rd_cnt, first_addr);
        end
    endtask

    task automatic test_reset_midline();
        int reads;
        drive_line(4, 100);
        reset = 1'b1;
        #1;
        total++;
        if ({lcd_de, lcd_hs, lcd_vs, vram_rd} !== 4'b0000 || lcd_rgb() !== 16'h0000 || vram_addr !== 13'd0) begin
            bad++;
            $display("[TB] FAIL midline_reset: de/hs/vs/rd=%b%b%b%b rgb=%h addr=%0d required all 0",
                     lcd_de, lcd_hs, lcd_vs, vram_rd, lcd_rgb(), vram_addr);
        end
        @(posedge dclk);
        #1;
        reset = 1'b0;
        reads = 0;
        for (int l = 0; l < 12; l++) begin
            drive_line(4, 4);
            reads += rd_cnt;
        end
        rd_cnt = reads;
        check_border_line("after_reset", 4);
        vs_pulse();
        drive_line(0, 2);
        for (int l = 1; l < 8; l++) drive_line(4, 2);
        drive_line(4, 2);
        total++;
        if (rd_cnt !== 2 || first_addr !== 13'd1) begin
            bad++;
            $display("[TB] FAIL resume_after_vs: reads=%0d addr=%0d required 2 and 1", rd_cnt, first_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[1]          = 16'h0001;
        mem[2]          = 16'h0002;
        mem[5]          = 16'hA5C3;
        mem[30]         = 16'h8001;
        mem[255*32 + 1] = 16'h00F0;
        mem[255*32 + 17] = 16'h1234;
        mem[255*32 + 30] = 16'h8000;
        test_reset();
        test_unsynced();
        test_first_word();
        test_last_row();
        test_coincident();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
